cla_arbiter: RTL
================

# cla_arbiter

Round-robin arbiter that shares one pipelined 32-bit carry-lookahead adder (`cla_32bit`) among `NUM_REQ` requesters. Each requester gets a valid/ready issue port. The arbiter registers the granted operands into the adder and tracks every in-flight operation with a tag pipeline matched to the adder latency. It then returns each registered result with the requester ID. It sits between client blocks and the single shared adder instance, one level above `cla_32bit` in the hierarchy.

## Interface
- `NUM_REQ`, 4, number of requesters (2..16)
- `DATA_W`, 32, operand width; must match the adder
- `ADD_LAT`, 2, clock edges from an `add_*` change to a valid `add_sum`/`add_cout`; 2 matches `cla_32bit`
- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous, active-high reset; the top level drives the adder's `rst_n` as `~rst`
- `req_valid`  in  NUM_REQ  per-requester operation request
- `req_a`  in  NUM_REQ*DATA_W  packed operands A; requester i occupies `[i*DATA_W +: DATA_W]`
- `req_b`  in  NUM_REQ*DATA_W  packed operands B
- `req_cin`  in  NUM_REQ  carry-in per requester
- `req_ready`  out  NUM_REQ  one-hot grant; combinational
- `add_a`, `add_b`  out  DATA_W  registered operands to the adder
- `add_cin`  out  1  registered carry-in to the adder
- `add_sum`  in  DATA_W  adder sum
- `add_cout`  in  1  adder carry-out
- `resp_valid`  out  1  one-cycle result pulse
- `resp_id`  out  $clog2(NUM_REQ)  requester index of the result
- `resp_sum`  out  DATA_W  registered sum
- `resp_cout`  out  1  registered carry-out
- `busy`  out  1  high while any operation is in flight

## Operation
- **Pointer.** The round-robin pointer `ptr` is `$clog2(NUM_REQ)` bits.
  - Arbitration scans `req_valid` starting at index `ptr`, upward, wrapping modulo NUM_REQ. The first set bit wins.
  - At most one grant per cycle.
- **Ready.** `req_ready[i]` = 1 only for the winner; all other bits are 0. `req_ready` may depend combinationally on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- **Transfer.** A transfer happens on a rising edge with `req_valid[i] & req_ready[i]`. On that edge:
  - the winner's operands load into `add_a`/`add_b`/`add_cin`;
  - tag stage 0 loads {valid=1, id=i};
  - `ptr` becomes (i+1) mod NUM_REQ.
- **No requests.** If no `req_valid` bit is set, `ptr` is held, tag stage 0 loads valid=0, and `add_*` hold their previous values.
- **Tag pipeline.** The tag pipeline is ADD_LAT+1 stages deep and shifts every cycle. No stall exists and responses have no backpressure.
- **Response.** When the last tag stage is valid: `resp_valid` = 1, `resp_id` = tag id, `resp_sum` = `add_sum`, `resp_cout` = `add_cout`, all captured together on the same edge.
- **Response values when idle.** When the last tag stage is invalid, `resp_valid` = 0 and `resp_sum`/`resp_cout`/`resp_id` hold their last values.
- **Arithmetic.** The arbiter performs none; {`resp_cout`,`resp_sum`} = A + B + Cin, computed modulo 2^(DATA_W+1) by the adder.
- **Busy.** `busy` = OR of all tag-stage valid bits.

## Timing
- **Reset values.** Outputs: `add_a` = 0, `add_b` = 0, `add_cin` = 0, `resp_valid` = 0, `resp_id` = 0, `resp_sum` = 0, `resp_cout` = 0, `busy` = 0. Internal: `ptr` = 0, all tag valid bits = 0.
- **Ready during reset.** While `rst` = 1, `req_ready` = 0.
- **Latency.** Grant edge k → `resp_valid` high during the cycle after edge k+ADD_LAT+1, i.e. ADD_LAT+1 cycles.
- **Throughput.** One operation per cycle. Back-to-back grants produce back-to-back `resp_valid` pulses in grant order.
- **Reset mid-operation.**
  - All in-flight tags are discarded; no `resp_valid` is produced for them.
  - `resp_valid` is 0 in the cycle after the reset edge.
  - No grant is issued on a reset edge.
- **Persistent requester.** A requester holding `req_valid` is granted at most once per NUM_REQ cycles while others are requesting. With all requesters active, grants rotate 0,1,…,NUM_REQ-1,0,…
- **Single requester.** A lone requester is granted every cycle.
- **Wrap-around.** A grant to index NUM_REQ-1 sets `ptr` to 0.
- **Simultaneous events.** When a new grant and a response occur on the same edge, both take effect independently.

## Test plan
- **Single request.** Reset, then requester 2 sends A=0x00000005, B=0x00000003, Cin=1 for one cycle → `req_ready`=4'b0100 in that cycle. Three cycles later `resp_valid`=1, `resp_id`=2, sum=0x00000009, cout=0; `busy` is high in between.
- **Round-robin fairness.** All four `req_valid` held high for 8 cycles → grant order 0,1,2,3,0,1,2,3. Responses arrive in the same order, each 3 cycles after its grant.
- **Carry boundary.** A=0xFFFFFFFF, B=0x00000000, Cin=1 → sum=0x00000000, cout=1. A=0xFFFFFFFF, B=0xFFFFFFFF, Cin=1 → sum=0xFFFFFFFF, cout=1.
- **Pointer wrap and skip.**
  - Requester 3 granted → `ptr`=0.
  - Then only requesters 1 and 3 are valid → grant 1 first, then 3.
- **Reset mid-flight.** Issue 3 back-to-back operations, then assert `rst` for one cycle one cycle after the last grant. Required response:
  - no `resp_valid` afterwards;
  - `busy`=0 and `ptr`=0 after reset;
  - a subsequent request returns the correct result.
- **Random scoreboard.** 100 cycles of random `req_valid` and random operands → every accepted operation returns exactly once, with the correct ID, and {cout,sum} = A+B+Cin.

Source files
------------

// File: rtl/cla_arbiter.sv
// Round-robin arbiter sharing one pipelined adder among NUM_REQ valid/ready requesters.
// Latency: grant edge to registered response is ADD_LAT+1 cycles; one operation per cycle.
// Backpressure: req_ready is a combinational one-hot grant; responses are never stalled.
module cla_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ADD_LAT = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_a,
    input  logic [NUM_REQ*DATA_W-1:0]  req_b,
    input  logic [NUM_REQ-1:0]         req_cin,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [DATA_W-1:0]          add_a,
    output logic [DATA_W-1:0]          add_b,
    output logic                       add_cin,
    input  logic [DATA_W-1:0]          add_sum,
    input  logic                       add_cout,
    output logic                       resp_valid,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic [DATA_W-1:0]          resp_sum,
    output logic                       resp_cout,
    output logic                       busy
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0]                ptr;
    logic [ID_W-1:0]                ptr_next;
    logic [NUM_REQ-1:0]             grant;
    logic                           grant_any;
    logic [ID_W-1:0]                grant_id;
    logic [ID_W:0]                  scan_idx;
    logic [ID_W-1:0]                scan_sel;
    logic [DATA_W-1:0]              sel_a;
    logic [DATA_W-1:0]              sel_b;
    logic                           sel_cin;
    logic [ADD_LAT:0]               tag_vld;
    logic [ADD_LAT:0][ID_W-1:0]     tag_id;

    // Scan requests from ptr upward with wrap; the first requester found wins.
    // The scan index is one bit wider so ptr+j never overflows before the wrap.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        scan_idx  = '0;
        scan_sel  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            scan_idx = {1'b0, ptr} + (ID_W+1)'(j);
            if (scan_idx >= (ID_W+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
            end
            scan_sel = scan_idx[ID_W-1:0];
            if (!grant_any && !rst && req_valid[scan_sel]) begin
                grant_any = 1'b1;
                grant_id  = scan_sel;
            end
        end
    end

    // Decode the winner into the one-hot ready vector.
    always_comb begin
        grant = '0;
        if (grant_any) begin
            grant[grant_id] = 1'b1;
        end
    end

    assign req_ready = grant;
    assign ptr_next  = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;

    // One-hot operand mux for the winning requester.
    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_cin = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_a   = req_a[i*DATA_W +: DATA_W];
                sel_b   = req_b[i*DATA_W +: DATA_W];
                sel_cin = req_cin[i];
            end
        end
    end

    // Advance the round-robin pointer past the winner; hold it when nobody asks.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_any) begin
            ptr <= ptr_next;
        end
    end

    // Register the granted operands into the adder; hold them when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            add_a   <= '0;
            add_b   <= '0;
            add_cin <= 1'b0;
        end else if (grant_any) begin
            add_a   <= sel_a;
            add_b   <= sel_b;
            add_cin <= sel_cin;
        end
    end

    // Tag pipeline tracks each in-flight operation alongside the adder stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld <= '0;
            tag_id  <= '0;
        end else begin
            tag_vld <= {tag_vld[ADD_LAT-1:0], grant_any};
            tag_id  <= {tag_id[ADD_LAT-1:0], grant_id};
        end
    end

    // Capture the adder result with its tag when the last stage is valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_sum   <= '0;
            resp_cout  <= 1'b0;
        end else begin
            resp_valid <= tag_vld[ADD_LAT];
            if (tag_vld[ADD_LAT]) begin
                resp_id   <= tag_id[ADD_LAT];
                resp_sum  <= add_sum;
                resp_cout <= add_cout;
            end
        end
    end

    assign busy = |tag_vld;

endmodule
